// File: rtl/muldiv_sequencer.sv
// Sequential mul/div unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MULDIV_FAST_ZERO_EN: zero operands bypass the iteration and finish right after PREP.
module muldiv_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div_by_zero_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0]   ONES_W   = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0]   ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [2*DATA_W-1:0] ONE_2W   = {{(2*DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W-1);

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return (~v) + ONE_W;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
    return (~v) + ONE_2W;
  endfunction

  function automatic logic [DATA_W-1:0] abs_w(input logic [DATA_W-1:0] v, input logic sgn);
    if (sgn && v[DATA_W-1]) begin
      return neg_w(v);
    end else begin
      return v;
    end
  endfunction

  state_t              state_q, state_d;
  logic                is_div_q, is_div_d;
  logic [DATA_W-1:0]   a_abs_q, a_abs_d;
  logic [DATA_W-1:0]   b_abs_q, b_abs_d;
  logic [DATA_W-1:0]   a_raw_q, a_raw_d;
  logic                res_neg_q, res_neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic                b_zero_q, b_zero_d;
  logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  logic                signed_op_s;
  logic                div_zero_s;
  logic                fast_zero_s;
  logic [DATA_W:0]     mul_sum_s;
  logic [DATA_W:0]     mul_top_s;
  logic [DATA_W:0]     rem_sh_s;
  logic [DATA_W:0]     diff_s;
  logic [DATA_W-1:0]   div_hi_s;
  logic [DATA_W-1:0]   div_lo_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   fix_hi_s;
  logic [DATA_W-1:0]   fix_lo_s;
  logic [DATA_W-1:0]   zero_hi_s;
  logic [DATA_W-1:0]   zero_lo_s;

  assign signed_op_s = ~op_i[0];
  assign div_zero_s  = is_div_q & b_zero_q;

`ifdef MULDIV_FAST_ZERO_EN
  assign fast_zero_s = (a_abs_q == ZERO_W) | b_zero_q;
`else
  assign fast_zero_s = 1'b0;
`endif

  // One iteration of each algorithm; carry/borrow kept in an extra top bit
  always_comb begin
    mul_sum_s = {1'b0, acc_hi_q} + {1'b0, a_abs_q};
    if (acc_lo_q[0]) begin
      mul_top_s = mul_sum_s;
    end else begin
      mul_top_s = {1'b0, acc_hi_q};
    end
    rem_sh_s = {acc_hi_q, acc_lo_q[DATA_W-1]};
    diff_s   = rem_sh_s - {1'b0, b_abs_q};
    if (!diff_s[DATA_W]) begin
      div_hi_s = diff_s[DATA_W-1:0];
      div_lo_s = {acc_lo_q[DATA_W-2:0], 1'b1};
    end else begin
      div_hi_s = rem_sh_s[DATA_W-1:0];
      div_lo_s = {acc_lo_q[DATA_W-2:0], 1'b0};
    end
  end

  // Sign fix-up of the magnitude result, plus the fixed divide-by-zero pattern
  always_comb begin
    prod_s = {acc_hi_q, acc_lo_q};
    if (div_zero_s) begin
      fix_hi_s = a_raw_q;
      fix_lo_s = ONES_W;
    end else if (is_div_q) begin
      fix_hi_s = rem_neg_q ? neg_w(acc_hi_q) : acc_hi_q;
      fix_lo_s = res_neg_q ? neg_w(acc_lo_q) : acc_lo_q;
    end else begin
      {fix_hi_s, fix_lo_s} = res_neg_q ? neg_2w(prod_s) : prod_s;
    end
    if (div_zero_s) begin
      zero_hi_s = a_raw_q;
      zero_lo_s = ONES_W;
    end else begin
      zero_hi_s = ZERO_W;
      zero_lo_s = ZERO_W;
    end
  end

  // Next-state and datapath control for the sequencer
  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    a_abs_d   = a_abs_q;
    b_abs_d   = b_abs_q;
    a_raw_d   = a_raw_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    b_zero_d  = b_zero_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_PREP;
          busy_d    = 1'b1;
          dbz_d     = 1'b0;
          is_div_d  = op_i[1];
          a_abs_d   = abs_w(src_a_i, signed_op_s);
          b_abs_d   = abs_w(src_b_i, signed_op_s);
          a_raw_d   = src_a_i;
          res_neg_d = signed_op_s & (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
          rem_neg_d = signed_op_s & src_a_i[DATA_W-1];
          b_zero_d  = (src_b_i == ZERO_W);
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_PREP: begin
        if (fast_zero_s) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = div_zero_s;
          hi_d    = zero_hi_s;
          lo_d    = zero_lo_s;
        end else begin
          state_d  = S_CALC;
          cnt_d    = CNT_ZERO;
          acc_hi_d = ZERO_W;
          acc_lo_d = is_div_q ? a_abs_q : b_abs_q;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_hi_d = div_hi_s;
          acc_lo_d = div_lo_s;
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_top_s, acc_lo_q[DATA_W-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = div_zero_s;
        hi_d    = fix_hi_s;
        lo_d    = fix_lo_s;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      a_abs_q   <= ZERO_W;
      b_abs_q   <= ZERO_W;
      a_raw_q   <= ZERO_W;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      acc_hi_q  <= ZERO_W;
      acc_lo_q  <= ZERO_W;
      cnt_q     <= CNT_ZERO;
      hi_q      <= ZERO_W;
      lo_q      <= ZERO_W;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      a_abs_q   <= a_abs_d;
      b_abs_q   <= b_abs_d;
      a_raw_q   <= a_raw_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      b_zero_q  <= b_zero_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are queued at issue and checked at done_o.
module tb_muldiv_sequencer;

  localparam int LAT = 34;
`ifdef MULDIV_FAST_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_by_zero_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  muldiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o), .div_by_zero_o(div_by_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent 64-bit reference: {dbz, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 64'd0;
    if (op[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin sq = sa / sb; sr = sa % sb; r = {sr[31:0], sq[31:0]}; end
      default: r = {32'((ua % ub)), 32'((ua / ub))};
    endcase
    return {1'b0, r};
  endfunction

  task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo, input logic dbz, input int lat);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dbz = dbz; e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Called off-edge; returns just after the accepting edge with inputs scrambled
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; src_a_i = a; src_b_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; src_a_i = $urandom; src_b_i = $urandom; op_i = 2'($urandom_range(0, 3));
  endtask

  // Waits (bounded) for done_o; lat is the edge index after which done_o was seen
  task automatic wait_done(input int first, output int lat, output int busy_cnt);
    lat = first; busy_cnt = 0;
    while (done_o !== 1'b1 && lat < first + 200) begin
      if (busy_o === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; src_a_i = 32'd0; src_b_i = 32'd0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    compared++;
    if ({busy_o, done_o, div_by_zero_o} !== 3'b000) begin
      mismatched++; $display("FAIL reset_flags: busy/done/dbz got %b want 000", {busy_o, done_o, div_by_zero_o});
    end
    compared++;
    if ({hi_o, lo_o} !== 64'd0) begin
      mismatched++; $display("FAIL reset_data: hi/lo got %h_%h want 0", hi_o, lo_o);
    end
  endtask

  task automatic test_mul();
    int lat, bc; exp_t e;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT);
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(0, lat, bc);
    e = sb_q.pop_front();
    compared++;
    if ({div_by_zero_o, hi_o, lo_o} !== {e.dbz, e.hi, e.lo} || lat != e.lat) begin
      mismatched++; $display("FAIL mul_signed: got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d", hi_o, lo_o, div_by_zero_o, lat, e.hi, e.lo, e.dbz, e.lat);
    end
    compared++;
    if (bc != 34) begin mismatched++; $display("FAIL mul_busy_cycles: got %0d want 34", bc); end
    @(posedge clk); #1;
    compared++;
    if (done_o !== 1'b0 || hi_o !== e.hi || lo_o !== e.lo) begin
      mismatched++; $display("FAIL done_pulse_hold: done=%b hi=%h lo=%h want done=0 hi=%h lo=%h", done_o, hi_o, lo_o, e.hi, e.lo);
    end
    push_exp(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT);
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, lat, bc);
    e = sb_q.pop_front();
    compared++;
    if ({div_by_zero_o, hi_o, lo_o} !== {e.dbz, e.hi, e.lo} || lat != e.lat) begin
      mismatched++; $display("FAIL mul_unsigned: got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d", hi_o, lo_o, div_by_zero_o, lat, e.hi, e.lo, e.dbz, e.lat);
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops [5] = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b10};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd0, 32'd0};
    logic [31:0] bs  [5] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd5, 32'd5};
    logic [31:0] his [5] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0};
    logic [31:0] los [5] = '{32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'd0, 32'd0};
    int          lats[5] = '{LAT, LAT, LAT, ZLAT, ZLAT};
    int lat, bc; exp_t e;
    for (int i = 0; i < 5; i++) begin
      push_exp(his[i], los[i], 1'b0, lats[i]);
      start_op(ops[i], as[i], bs[i]);
      wait_done(0, lat, bc);
      e = sb_q.pop_front();
      compared++;
      if ({div_by_zero_o, hi_o, lo_o} !== {e.dbz, e.hi, e.lo} || lat != e.lat) begin
        mismatched++; $display("FAIL div_case%0d: got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d", i, hi_o, lo_o, div_by_zero_o, lat, e.hi, e.lo, e.dbz, e.lat);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc; exp_t e;
    push_exp(32'h0000_0064, 32'hFFFF_FFFF, 1'b1, ZLAT);
    start_op(2'b11, 32'd100, 32'd0);
    wait_done(0, lat, bc);
    e = sb_q.pop_front();
    compared++;
    if ({div_by_zero_o, hi_o, lo_o} !== {e.dbz, e.hi, e.lo} || lat != e.lat) begin
      mismatched++; $display("FAIL div_zero_u: got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d", hi_o, lo_o, div_by_zero_o, lat, e.hi, e.lo, e.dbz, e.lat);
    end
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (div_by_zero_o !== 1'b1 || done_o !== 1'b0 || hi_o !== 32'h64) begin
      mismatched++; $display("FAIL dbz_hold: dbz=%b done=%b hi=%h want dbz=1 done=0 hi=00000064", div_by_zero_o, done_o, hi_o);
    end
    push_exp(32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1, ZLAT);
    start_op(2'b10, 32'hFFFF_FF9C, 32'd0);
    compared++;
    if (div_by_zero_o !== 1'b0) begin mismatched++; $display("FAIL dbz_clear_on_accept: got %b want 0", div_by_zero_o); end
    wait_done(0, lat, bc);
    e = sb_q.pop_front();
    compared++;
    if ({div_by_zero_o, hi_o, lo_o} !== {e.dbz, e.hi, e.lo} || lat != e.lat) begin
      mismatched++; $display("FAIL div_zero_s: got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d", hi_o, lo_o, div_by_zero_o, lat, e.hi, e.lo, e.dbz, e.lat);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc, extra; exp_t e;
    push_exp(32'd0, 32'd3, 1'b0, LAT);
    start_op(2'b11, 32'd9, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    op_i = 2'b01; src_a_i = 32'd5; src_b_i = 32'd5; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(10, lat, bc);
    e = sb_q.pop_front();
    compared++;
    if ({div_by_zero_o, hi_o, lo_o} !== {e.dbz, e.hi, e.lo} || lat != e.lat) begin
      mismatched++; $display("FAIL ignore_start: got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d", hi_o, lo_o, div_by_zero_o, lat, e.hi, e.lo, e.dbz, e.lat);
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) extra++;
    end
    compared++;
    if (extra != 0) begin mismatched++; $display("FAIL single_done: extra done pulses got %0d want 0", extra); end
  endtask

  task automatic test_mid_reset();
    int lat, bc, extra; exp_t e;
    start_op(2'b01, 32'h0000_1234, 32'h0000_0010);
    repeat (14) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    compared++;
    if ({busy_o, done_o, div_by_zero_o, hi_o, lo_o} !== 67'd0) begin
      mismatched++; $display("FAIL mid_reset: busy=%b done=%b dbz=%b hi=%h lo=%h want all 0", busy_o, done_o, div_by_zero_o, hi_o, lo_o);
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) extra++;
    end
    compared++;
    if (extra != 0) begin mismatched++; $display("FAIL abandoned_done: done pulses got %0d want 0", extra); end
    push_exp(32'd0, 32'd6, 1'b0, LAT);
    start_op(2'b01, 32'd2, 32'd3);
    wait_done(0, lat, bc);
    e = sb_q.pop_front();
    compared++;
    if ({div_by_zero_o, hi_o, lo_o} !== {e.dbz, e.hi, e.lo} || lat != e.lat) begin
      mismatched++; $display("FAIL after_reset: got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d", hi_o, lo_o, div_by_zero_o, lat, e.hi, e.lo, e.dbz, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; exp_t e;
    push_exp(32'd7, 32'hFFFF_FFFF, 1'b1, ZLAT);
    start_op(2'b11, 32'd7, 32'd0);
    wait_done(0, lat, bc);
    e = sb_q.pop_front();
    compared++;
    if ({div_by_zero_o, hi_o, lo_o} !== {e.dbz, e.hi, e.lo} || lat != e.lat) begin
      mismatched++; $display("FAIL b2b_first: got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d", hi_o, lo_o, div_by_zero_o, lat, e.hi, e.lo, e.dbz, e.lat);
    end
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, LAT);
    start_op(2'b00, 32'hFFFF_FFFD, 32'd4);
    compared++;
    if ({busy_o, done_o, div_by_zero_o} !== 3'b100) begin
      mismatched++; $display("FAIL b2b_accept: busy/done/dbz got %b want 100", {busy_o, done_o, div_by_zero_o});
    end
    wait_done(0, lat, bc);
    e = sb_q.pop_front();
    compared++;
    if ({div_by_zero_o, hi_o, lo_o} !== {e.dbz, e.hi, e.lo} || lat != e.lat) begin
      mismatched++; $display("FAIL b2b_second: got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d", hi_o, lo_o, div_by_zero_o, lat, e.hi, e.lo, e.dbz, e.lat);
    end
  endtask

  task automatic test_random();
    int lat, bc; exp_t e;
    logic [1:0] op; logic [31:0] a, b; logic [64:0] m;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      if (i % 4 == 1) b = 32'd0;
      if (i % 6 == 2) a = 32'd0;
      if (i % 5 == 3) a = 32'h8000_0000;
      if (i % 3 == 0) b = 32'($urandom_range(1, 300));
      m = model(op, a, b);
      push_exp(m[63:32], m[31:0], m[64], (a == 32'd0 || b == 32'd0) ? ZLAT : LAT);
      start_op(op, a, b);
      wait_done(0, lat, bc);
      e = sb_q.pop_front();
      compared++;
      if ({div_by_zero_o, hi_o, lo_o} !== {e.dbz, e.hi, e.lo} || lat != e.lat) begin
        mismatched++; $display("FAIL random%0d op=%b a=%h b=%h: got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d", i, op, a, b, hi_o, lo_o, div_by_zero_o, lat, e.hi, e.lo, e.dbz, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
